// File: rtl/timer_pkg.sv
// Shared constants for the MM:SS countdown timer.
// Digit limits and digit-select encodings.
package timer_pkg;

  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  typedef enum logic [1:0] {
    SEL_SEGS0 = 2'd0,
    SEL_SEGS1 = 2'd1,
    SEL_MINS0 = 2'd2,
    SEL_MINS1 = 2'd3
  } sel_e;

endpackage

// File: rtl/bcd_digit.sv
// One wrapping BCD digit, 0..MAX.
// Borrow is raised on a decrement taken at zero.
module bcd_digit
  import timer_pkg::*;
#(
  parameter logic [3:0] MAX = UNITS_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] value,
  output logic       borrow
);

  logic [3:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc && !dec) begin
      value_d = (value_q >= MAX) ? 4'd0 : value_q + 4'd1;
    end else if (dec && !inc) begin
      value_d = (value_q == 4'd0 || value_q > MAX) ? MAX
                                                    : value_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) value_q <= 4'd0;
    else        value_q <= value_d;
  end

  assign value  = value_q;
  assign borrow = dec && !inc && (value_q == 4'd0);

endmodule

// File: rtl/timer_counter.sv
// MM:SS countdown timer with button digit setting.
// One-second prescaler drives a BCD borrow chain.
module timer_counter
  import timer_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_run,
  input  logic [1:0] i_choose,
  input  logic       i_B_U,
  input  logic       i_B_D,
  output logic [3:0] o_mins1,
  output logic [3:0] o_mins0,
  output logic [3:0] o_segs1,
  output logic [3:0] o_segs0,
  output logic       o_zero,
  output logic       o_tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bu_q, bu_d;
  logic          bd_q, bd_d;
  logic          armed_q, armed_d;
  logic          tick_q, tick_d;

  logic       up_e, dn_e, set_up, set_dn;
  logic       tick, step;
  logic [3:0] sel_oh;
  logic [3:0] inc, dec, brw;

  // First clock after reset only samples levels, so held buttons
  // never count as a press.
  assign up_e   = armed_q && i_B_U && !bu_q;
  assign dn_e   = armed_q && i_B_D && !bd_q;
  assign set_up = !i_run && up_e && !dn_e;
  assign set_dn = !i_run && dn_e && !up_e;

  assign tick = i_run && (cnt_q == LAST);
  assign step = tick && !o_zero;

  always_comb begin
    sel_oh = 4'b0000;
    unique case (i_choose)
      SEL_SEGS0: sel_oh = 4'b0001;
      SEL_SEGS1: sel_oh = 4'b0010;
      SEL_MINS0: sel_oh = 4'b0100;
      SEL_MINS1: sel_oh = 4'b1000;
      default:   sel_oh = 4'b0000;
    endcase
  end

  always_comb begin
    inc    = {4{set_up}} & sel_oh;
    dec[0] = (set_dn && sel_oh[0]) || step;
    dec[1] = (set_dn && sel_oh[1]) || (step && brw[0]);
    dec[2] = (set_dn && sel_oh[2]) || (step && brw[1]);
    dec[3] = (set_dn && sel_oh[3]) || (step && brw[2]);
  end

  always_comb begin
    cnt_d   = cnt_q;
    bu_d    = i_B_U;
    bd_d    = i_B_D;
    armed_d = 1'b1;
    tick_d  = tick;
    if (!i_run || cnt_q == LAST) cnt_d = '0;
    else                         cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      bu_q    <= 1'b0;
      bd_q    <= 1'b0;
      armed_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bu_q    <= bu_d;
      bd_q    <= bd_d;
      armed_q <= armed_d;
      tick_q  <= tick_d;
    end
  end

  bcd_digit #(.MAX(UNITS_MAX)) u_segs0 (
    .clk(clk), .reset(reset), .inc(inc[0]), .dec(dec[0]),
    .value(o_segs0), .borrow(brw[0])
  );

  bcd_digit #(.MAX(TENS_MAX)) u_segs1 (
    .clk(clk), .reset(reset), .inc(inc[1]), .dec(dec[1]),
    .value(o_segs1), .borrow(brw[1])
  );

  bcd_digit #(.MAX(UNITS_MAX)) u_mins0 (
    .clk(clk), .reset(reset), .inc(inc[2]), .dec(dec[2]),
    .value(o_mins0), .borrow(brw[2])
  );

  bcd_digit #(.MAX(TENS_MAX)) u_mins1 (
    .clk(clk), .reset(reset), .inc(inc[3]), .dec(dec[3]),
    .value(o_mins1), .borrow(brw[3])
  );

  assign o_zero = (o_mins1 == 4'd0) && (o_mins0 == 4'd0) &&
                  (o_segs1 == 4'd0) && (o_segs0 == 4'd0);
  assign o_tick = tick_q;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter with CLK_HZ=4.
// Stimulus queues expectations; monitor pops on tick or check strobe.
module tb_timer_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_run = 1'b0;
  logic [1:0] i_choose = 2'd0;
  logic       i_B_U = 1'b0;
  logic       i_B_D = 1'b0;
  logic [3:0] o_mins1, o_mins0, o_segs1, o_segs0;
  logic       o_zero, o_tick;
  logic       chk = 1'b0;

  typedef struct {
    string       name;
    logic [15:0] d;
    logic        z;
    logic        t;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   total = 0;
  int   cyc = 0;

  timer_counter #(.CLK_HZ(4)) dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_choose(i_choose),
    .i_B_U(i_B_U), .i_B_D(i_B_D),
    .o_mins1(o_mins1), .o_mins0(o_mins0),
    .o_segs1(o_segs1), .o_segs0(o_segs0),
    .o_zero(o_zero), .o_tick(o_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset && (o_tick || chk)) begin
      total++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: act=%h%h:%h%h tick=%0b",
                 o_mins1, o_mins0, o_segs1, o_segs0, o_tick);
      end else begin
        exp_t e;
        logic [15:0] a;
        e = sb.pop_front();
        a = {o_mins1, o_mins0, o_segs1, o_segs0};
        if (a !== e.d || o_zero !== e.z || o_tick !== e.t ||
            (e.cyc >= 0 && cyc != e.cyc)) begin
          errors++;
          $display("FAIL %s: act=%h z=%0b t=%0b cyc=%0d req=%h z=%0b t=%0b cyc=%0d",
                   e.name, a, o_zero, o_tick, cyc, e.d, e.z, e.t, e.cyc);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(string n, logic [15:0] d);
    exp_t e;
    e = '{n, d, d == 16'h0, 1'b0, -1};
    sb.push_back(e);
    step(1);
    chk = 1'b1;
    step(1);
    chk = 1'b0;
  endtask

  task automatic press(logic [1:0] sel, logic u, logic d, int n);
    i_choose = sel;
    repeat (n) begin
      i_B_U = u;
      i_B_D = d;
      step(1);
      i_B_U = 1'b0;
      i_B_D = 1'b0;
      step(1);
    end
  endtask

  task automatic do_reset();
    step(1);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  // Queue nt tick expectations then run for nc cycles.
  task automatic run(string n, logic [15:0] v[], int nc);
    int c0;
    step(1);
    c0 = cyc;
    foreach (v[k]) begin
      exp_t e;
      e = '{$sformatf("%s_%0d", n, k), v[k], v[k] == 16'h0,
            1'b1, c0 + 4 * (k + 1)};
      sb.push_back(e);
    end
    i_run = 1'b1;
    step(nc);
    i_run = 1'b0;
    step(2);
  endtask

  initial begin
    logic [15:0] v[];
    step(2);
    total++;
    if (!(o_zero === 1'b1 && {o_mins1, o_mins0, o_segs1, o_segs0} === 16'h0)) begin
      errors++;
      $display("FAIL reset_state: act=%h%h:%h%h z=%0b req=0000 z=1",
               o_mins1, o_mins0, o_segs1, o_segs0, o_zero);
    end
    reset = 1'b1;
    step(1);
    check("after_reset", 16'h0000);

    press(2'd1, 1'b1, 1'b0, 3);
    check("segs1_up3", 16'h0030);
    press(2'd1, 1'b1, 1'b0, 4);
    check("segs1_wrap", 16'h0010);

    do_reset();
    press(2'd0, 1'b0, 1'b1, 1);
    check("segs0_dn_wrap", 16'h0009);
    press(2'd3, 1'b0, 1'b1, 1);
    check("mins1_dn_wrap", 16'h5009);

    do_reset();
    press(2'd3, 1'b1, 1'b0, 1);
    check("load_1000", 16'h1000);
    v = '{16'h0959, 16'h0958};
    run("tick_1000", v, 8);
    check("frozen_0958", 16'h0958);

    i_run = 1'b1;
    step(2);
    i_run = 1'b0;
    step(1);
    check("midsec_drop", 16'h0958);
    v = '{16'h0957};
    run("after_drop", v, 4);

    i_choose = 2'd0;
    i_run = 1'b1;
    i_B_U = 1'b1;
    step(1);
    i_B_U = 1'b0;
    step(1);
    i_run = 1'b0;
    step(1);
    check("run_btn_ignored", 16'h0957);
    press(2'd0, 1'b1, 1'b1, 1);
    check("simul_ud", 16'h0957);
    i_B_U = 1'b1;
    step(3);
    i_B_U = 1'b0;
    step(1);
    check("held_one_step", 16'h0958);

    do_reset();
    press(2'd0, 1'b1, 1'b0, 1);
    check("load_0001", 16'h0001);
    v = '{16'h0000, 16'h0000, 16'h0000};
    run("zero_hold", v, 12);

    i_B_U = 1'b1;
    step(1);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(3);
    i_B_U = 1'b0;
    step(1);
    check("held_thru_reset", 16'h0000);

    press(2'd3, 1'b1, 1'b0, 1);
    press(2'd2, 1'b1, 1'b0, 2);
    press(2'd1, 1'b1, 1'b0, 3);
    press(2'd0, 1'b1, 1'b0, 4);
    check("load_1234", 16'h1234);
    i_run = 1'b1;
    step(2);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (!(o_zero === 1'b1 && {o_mins1, o_mins0, o_segs1, o_segs0} === 16'h0)) begin
      errors++;
      $display("FAIL async_reset: act=%h%h:%h%h z=%0b req=0000 z=1",
               o_mins1, o_mins0, o_segs1, o_segs0, o_zero);
    end
    i_run = 1'b0;
    step(2);

    for (int k = 0; k < 50 && sb.size() != 0; k++) step(1);
    if (sb.size() != 0) begin
      total++;
      errors++;
      $display("FAIL drain: act=%0d pending req=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule
